// File: rtl/riscv_alu_pkg.sv
// Shared encodings for the iterative ALU: operation codes, FSM states and op-class helpers.
package riscv_alu_pkg;

  localparam int unsigned CTL_W = 4;

  localparam logic [CTL_W-1:0] ALU_AND   = 4'd0;
  localparam logic [CTL_W-1:0] ALU_OR    = 4'd1;
  localparam logic [CTL_W-1:0] ALU_ADD   = 4'd2;
  localparam logic [CTL_W-1:0] ALU_MUL   = 4'd3;
  localparam logic [CTL_W-1:0] ALU_MULHU = 4'd4;
  localparam logic [CTL_W-1:0] ALU_MULH  = 4'd5;
  localparam logic [CTL_W-1:0] ALU_SUB   = 4'd6;
  localparam logic [CTL_W-1:0] ALU_SLT   = 4'd7;
  localparam logic [CTL_W-1:0] ALU_DIV   = 4'd8;
  localparam logic [CTL_W-1:0] ALU_DIVU  = 4'd9;
  localparam logic [CTL_W-1:0] ALU_REM   = 4'd10;
  localparam logic [CTL_W-1:0] ALU_REMU  = 4'd11;
  localparam logic [CTL_W-1:0] ALU_NOR   = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  // Multi-cycle multiply/divide ops
  function automatic logic is_iter_op(input logic [CTL_W-1:0] op);
    case (op)
      ALU_MUL, ALU_MULHU, ALU_MULH,
      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: return 1'b1;
      default:                              return 1'b0;
    endcase
  endfunction

  function automatic logic is_div_op(input logic [CTL_W-1:0] op);
    case (op)
      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: return 1'b1;
      default:                              return 1'b0;
    endcase
  endfunction

  // Ops whose operands are two's-complement and need magnitude conversion
  function automatic logic is_signed_op(input logic [CTL_W-1:0] op);
    case (op)
      ALU_MULH, ALU_DIV, ALU_REM: return 1'b1;
      default:                    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/riscv_muldiv_iter.sv
// One-bit-per-cycle shift-add multiplier / restoring divider on operand magnitudes.
// done_c and result_c are valid in the final iteration cycle, result already sign-corrected.
module riscv_muldiv_iter
  import riscv_alu_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [CTL_W-1:0] op_i,
  input  logic [XLEN-1:0]  a_i,
  input  logic [XLEN-1:0]  b_i,
  output logic             done_c,
  output logic [XLEN-1:0]  result_c
);

  localparam int unsigned CW = $clog2(XLEN);

  logic [2*XLEN-1:0] acc_q, acc_d, prod_c;
  logic [XLEN-1:0]   opd_q, a_mag, b_mag, quo_c, rem_c;
  logic [CTL_W-1:0]  op_q;
  logic [CW-1:0]     cnt_q;
  logic              busy_q, neg_q, rneg_q, sa, sb;
  logic [XLEN:0]     shifted, diff, sum;

  assign sa    = is_signed_op(op_i) & a_i[XLEN-1];
  assign sb    = is_signed_op(op_i) & b_i[XLEN-1];
  assign a_mag = sa ? -a_i : a_i;
  assign b_mag = sb ? -b_i : b_i;

  // One iteration: acc holds {partial product, multiplier} or {remainder, quotient}
  always_comb begin
    acc_d   = acc_q;
    shifted = '0;
    diff    = '0;
    sum     = '0;
    if (is_div_op(op_q)) begin
      shifted = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
      diff    = shifted - {1'b0, opd_q};
      if (!diff[XLEN]) acc_d = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      else             acc_d = {shifted[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end else begin
      sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opd_q} : '0);
      acc_d = {sum, acc_q[XLEN-1:1]};
    end
  end

  // Sign correction applied once, on the final iteration's output
  always_comb begin
    prod_c   = neg_q ? -acc_d : acc_d;
    quo_c    = neg_q ? -acc_d[XLEN-1:0] : acc_d[XLEN-1:0];
    rem_c    = rneg_q ? -acc_d[2*XLEN-1:XLEN] : acc_d[2*XLEN-1:XLEN];
    result_c = '0;
    case (op_q)
      ALU_MUL:   result_c = acc_d[XLEN-1:0];
      ALU_MULHU: result_c = acc_d[2*XLEN-1:XLEN];
      ALU_MULH:  result_c = prod_c[2*XLEN-1:XLEN];
      ALU_DIV:   result_c = quo_c;
      ALU_DIVU:  result_c = acc_d[XLEN-1:0];
      ALU_REM:   result_c = rem_c;
      ALU_REMU:  result_c = acc_d[2*XLEN-1:XLEN];
      default:   result_c = '0;
    endcase
  end

  assign done_c = busy_q && (cnt_q == CW'(XLEN - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q  <= '0;
      opd_q  <= '0;
      op_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
    end else if (start_i) begin
      acc_q  <= is_div_op(op_i) ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
      opd_q  <= is_div_op(op_i) ? b_mag : a_mag;
      op_q   <= op_i;
      cnt_q  <= '0;
      busy_q <= 1'b1;
      // Divide by zero keeps the all-ones quotient unsigned
      neg_q  <= (sa ^ sb) & (b_i != '0);
      rneg_q <= sa;
    end else if (busy_q) begin
      acc_q <= acc_d;
      cnt_q <= cnt_q + CW'(1);
      if (done_c) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/riscv_iter_alu.sv
// RISC-V style ALU with valid/ready handshake; single-cycle logic ops plus iterative mul/div.
module riscv_iter_alu
  import riscv_alu_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CTL_W-1:0] ALUctl,
  input  logic [XLEN-1:0]  A,
  input  logic [XLEN-1:0]  B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  ALUout,
  output logic             Zero
);

  alu_state_e      state_q, state_d;
  logic            in_ready_q, in_ready_d, out_valid_q, out_valid_d, zero_q, zero_d;
  logic [XLEN-1:0] aluout_q, aluout_d, single_c, md_result_c;
  logic            accept_c, md_start_c, md_done_c;

  function automatic logic [XLEN-1:0] single_op(input logic [CTL_W-1:0] op,
                                                input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
    case (op)
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_SLT: return XLEN'($signed(a) < $signed(b));
      ALU_NOR: return ~(a | b);
      default: return '0;
    endcase
  endfunction

  assign single_c   = single_op(ALUctl, A, B);
  assign accept_c   = in_valid && (state_q == ST_IDLE);
  assign md_start_c = accept_c && is_iter_op(ALUctl);

  riscv_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
    .clk      (clk),
    .reset    (reset),
    .start_i  (md_start_c),
    .op_i     (ALUctl),
    .a_i      (A),
    .b_i      (B),
    .done_c   (md_done_c),
    .result_c (md_result_c)
  );

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    aluout_d    = aluout_q;
    zero_d      = zero_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          in_ready_d = 1'b0;
          if (is_iter_op(ALUctl)) begin
            state_d = ST_BUSY;
          end else begin
            state_d     = ST_DONE;
            out_valid_d = 1'b1;
            aluout_d    = single_c;
            zero_d      = (single_c == '0);
          end
        end
      end
      ST_BUSY: begin
        if (md_done_c) begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
          aluout_d    = md_result_c;
          zero_d      = (md_result_c == '0);
        end
      end
      ST_DONE: begin
        // Retire returns to IDLE only; next accept is at the following edge
        if (out_ready) begin
          state_d     = ST_IDLE;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
          aluout_d    = '0;
          zero_d      = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        aluout_d    = '0;
        zero_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      aluout_q    <= '0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      aluout_q    <= aluout_d;
      zero_q      <= zero_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign ALUout    = aluout_q;
  assign Zero      = zero_q;

endmodule

// File: tb/tb_riscv_iter_alu.sv
// Directed bench for riscv_iter_alu (XLEN=64) with hand-computed expected results.
module tb_riscv_iter_alu;
  import riscv_alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, out_valid, out_ready, Zero;
  logic [3:0]  ALUctl;
  logic [63:0] A, B, ALUout;
  int          n_tests = 0;
  int          n_fail  = 0;

  riscv_iter_alu #(.XLEN(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ALUctl    (ALUctl),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALUout    (ALUout),
    .Zero      (Zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request, scramble inputs after accept, then check latency, result, Zero and retire
  task automatic run_op(input string tag, input logic [3:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp, input int exp_lat);
    int lat;
    check({tag, " ready"}, 64'(in_ready), 64'd1);
    ALUctl = op; A = a; B = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; ALUctl = 4'hE; A = ~a; B = ~b;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " result"}, ALUout, exp);
    check({tag, " zero"}, 64'(Zero), 64'(exp == 64'd0));
    @(posedge clk); #1;
    check({tag, " retired"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int seen;
    reset = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; ALUctl = ALU_ADD; A = 64'd5; B = 64'd6;
    repeat (2) @(posedge clk);
    #1;
    check("rst in_ready", 64'(in_ready), 64'd1);
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst aluout", ALUout, 64'd0);
    check("rst zero", 64'(Zero), 64'd0);
    reset = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    check("post rst idle", 64'(out_valid), 64'd0);

    run_op("add",   ALU_ADD,   64'd1560, 64'd3, 64'd1563, 1);
    run_op("sub",   ALU_SUB,   64'd3, 64'd3, 64'd0, 1);
    run_op("subwr", ALU_SUB,   64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run_op("addwr", ALU_ADD,   64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 1);
    run_op("and",   ALU_AND,   64'hF0F0, 64'h0FF0, 64'h00F0, 1);
    run_op("or",    ALU_OR,    64'hF000, 64'h000F, 64'hF00F, 1);
    run_op("nor",   ALU_NOR,   64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run_op("slt",   ALU_SLT,   64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 1);
    run_op("sltn",  ALU_SLT,   64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
    run_op("rsvd",  4'd13,     64'd7, 64'd9, 64'd0, 1);

    run_op("mul",   ALU_MUL,   64'd1560, 64'd3, 64'd4680, 65);
    run_op("mulh",  ALU_MULH,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 65);
    run_op("mulhn", ALU_MULH,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run_op("mulhu", ALU_MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
           64'hFFFF_FFFF_FFFF_FFFE, 65);
    run_op("divu",  ALU_DIVU,  64'd1560, 64'd3, 64'd520, 65);
    run_op("remu",  ALU_REMU,  64'd1560, 64'd3, 64'd0, 65);
    run_op("divu0", ALU_DIVU,  64'd1560, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run_op("remu0", ALU_REMU,  64'd1560, 64'd0, 64'd1560, 65);
    run_op("divov", ALU_DIV,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h8000_0000_0000_0000, 65);
    run_op("remov", ALU_REM,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 65);
    run_op("div",   ALU_DIV,   64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    run_op("rem",   ALU_REM,   64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run_op("div0s", ALU_DIV,   64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run_op("rem0s", ALU_REM,   64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 64'hFFFF_FFFF_FFFF_FFF9, 65);

    // Backpressure: result held for 10 cycles while new requests are refused
    out_ready = 1'b0;
    ALUctl = ALU_ADD; A = 64'd10; B = 64'd20; in_valid = 1'b1;
    @(posedge clk); #1;
    A = 64'd1; B = 64'd1;
    check("bp valid", 64'(out_valid), 64'd1);
    check("bp first", ALUout, 64'd30);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp hold", ALUout, 64'd30);
      check("bp in_ready", 64'(in_ready), 64'd0);
      check("bp out_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp retire valid", 64'(out_valid), 64'd0);
    check("bp retire ready", 64'(in_ready), 64'd1);
    check("bp retire data", ALUout, 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp next valid", 64'(out_valid), 64'd1);
    check("bp next data", ALUout, 64'd2);
    @(posedge clk); #1;
    check("bp next retired", 64'(out_valid), 64'd0);

    // Reset in the middle of a divide discards it
    ALUctl = ALU_DIV; A = 64'd1000; B = 64'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    check("mid busy ready", 64'(in_ready), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid rst ready", 64'(in_ready), 64'd1);
    check("mid rst valid", 64'(out_valid), 64'd0);
    check("mid rst data", ALUout, 64'd0);
    seen = 0;
    repeat (70) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("mid rst no pulse", 64'(seen), 64'd0);
    run_op("add after rst", ALU_ADD, 64'd1, 64'd1, 64'd2, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_iter_alu.md
RISCV_ITER_ALU -- requirements
Module: riscv_iter_alu

Interface
REQ-001 SHALL have parameter XLEN, default 64: operand/result width; legal values 32 and 64.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  request present.
REQ-005 SHALL have port in_ready  output  1  unit can accept a request.
REQ-006 SHALL have port ALUctl  input  4  operation code.
REQ-007 SHALL have ports A, B  input  XLEN each  operands.
REQ-008 SHALL have port out_valid  output  1  result present.
REQ-009 SHALL have port out_ready  input  1  consumer takes result.
REQ-010 SHALL have port ALUout  output  XLEN  result.
REQ-011 SHALL have port Zero  output  1  high when ALUout is all zeros.

Function
REQ-012 SHALL decode ALUctl: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT (signed, result 0/1), 12 NOR, 3 MUL (low XLEN bits), 4 MULHU, 5 MULH (signed x signed, high XLEN bits), 8 DIV, 9 DIVU, 10 REM, 11 REMU; all other codes SHALL yield ALUout=0.
REQ-013 SHALL accept a request on a rising edge where in_valid and in_ready are both high; operands and ALUctl SHALL be captured on that edge and ignored thereafter.
REQ-014 SHALL use FSM states IDLE, BUSY, DONE; in_ready SHALL be high only in IDLE.
REQ-015 Single-cycle ops (0,1,2,6,7,12,reserved): IDLE->DONE on accept; out_valid high in the cycle after acceptance.
REQ-016 Iterative ops (3-5, 8-11): IDLE->BUSY on accept; exactly XLEN BUSY cycles (one bit per cycle, shift-add multiply, restoring divide), then BUSY->DONE; out_valid high XLEN+1 cycles after acceptance.
REQ-017 In DONE, ALUout, Zero and out_valid SHALL hold stable until out_valid and out_ready are both high on an edge, then DONE->IDLE.
REQ-018 SHALL not accept a new request in the same cycle a result is retired (no bypass); minimum request spacing is 2 cycles.
REQ-019 ADD/SUB SHALL wrap modulo 2^XLEN; no overflow flag.
REQ-020 Signed MULH/DIV/REM SHALL operate on magnitudes and apply sign correction once in the final cycle; remainder sign SHALL follow dividend.
REQ-021 Divide by zero: DIV/DIVU result all ones; REM/REMU result = A; cycle count unchanged (XLEN+1).
REQ-022 Signed overflow (A = most negative, B = -1): DIV result = A; REM result = 0.
REQ-023 ALUout and Zero SHALL be 0 whenever out_valid is low.

Reset
REQ-024 On reset high at a rising edge: state IDLE, in_ready=1, out_valid=0, ALUout=0, Zero=0, all datapath registers cleared.
REQ-025 Reset SHALL take priority over every other event, including an in-flight BUSY operation or a pending DONE result, which SHALL be discarded without out_valid pulsing.
REQ-026 A request presented during the reset edge SHALL not be accepted.

Structure
REQ-027 ALUctl encodings, FSM state typedef and op-class (single/iterative, signed/unsigned) helper constants SHALL live in shared package riscv_alu_pkg.
REQ-028 The iterative multiply/divide datapath SHALL be one sub-module, riscv_muldiv_iter, driven by start/done with the FSM kept in riscv_iter_alu.

Verification (XLEN=64)
REQ-029 ADD A=1560 B=3, out_ready=1 -> out_valid 1 cycle after accept, ALUout=1563, Zero=0; SUB A=3 B=3 -> ALUout=0, Zero=1.
REQ-030 MUL A=1560 B=3 -> out_valid exactly 65 cycles after accept, ALUout=4680; MULH A=-1 B=-1 -> ALUout=0.
REQ-031 DIVU A=1560 B=3 -> 520; REMU -> 0; DIVU A=1560 B=0 -> 0xFFFF_FFFF_FFFF_FFFF; REMU A=1560 B=0 -> 1560.
REQ-032 DIV A=0x8000_0000_0000_0000 B=-1 -> ALUout=0x8000_0000_0000_0000; REM same operands -> 0; DIV A=-7 B=2 -> -3, REM -> -1.
REQ-033 out_ready low for 10 cycles after out_valid -> ALUout held, in_ready low throughout, in_valid requests not accepted; retire then next accept >= 1 cycle later.
REQ-034 reset asserted at BUSY cycle 20 of a DIV -> next cycle IDLE, in_ready=1, out_valid=0; following ADD 1+1 returns 2.
